fpm_operand_unpack: RTL and testbench
=====================================

Name: fpm_operand_unpack

Overview:
- Front end of the single-precision FP multiplier, upstream of the mantissa multiplier and the special-value result formatter.
- Accepts IEEE-754 binary32 operand pairs through a valid/ready handshake.
- Classifies each operand, flushes denormals to zero, and emits sign, biased exponent sum, hidden-bit mantissas and the nan/inf/zer special-case flags.
- 2-stage registered pipeline with full back-pressure, plus sticky exception status.

Parameters:
- BIAS, 127, exponent bias subtracted from the exponent sum.
- EXP_W, 10, width of the signed exponent-sum output; must be ≥ 10.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair A/B valid.
- in_ready  output  1  block can accept the pair this cycle.
- a  input  32  operand A, binary32.
- b  input  32  operand B, binary32.
- out_valid  output  1  result fields valid.
- out_ready  input  1  downstream accepts result.
- z_sign  output  1  a[31] XOR b[31].
- exp_sum  output  EXP_W  signed value eA + eB − BIAS.
- man_a  output  24  {1, a[22:0]}; 0 if A is zero or denormal.
- man_b  output  24  {1, b[22:0]}; 0 if B is zero or denormal.
- nan  output  1  result must be canonical NaN.
- inf  output  1  result must be signed infinity.
- zer  output  1  result must be signed zero.
- sticky_nan  output  1  a NaN result has been delivered since the last clear.
- sticky_inf  output  1  an inf result has been delivered since the last clear.
- sticky_clr  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset values (async, immediate on rst rise):
  - out_valid = 0.
  - All data outputs = 0.
  - nan, inf and zer = 0.
  - Both sticky flags = 0.
  - Both internal stage-valid bits = 0.
- Stage 1 (S1): on an in_valid && in_ready edge, register A and B. Also register each operand's class:
  - isnan: exp = FF and frac ≠ 0.
  - isinf: exp = FF and frac = 0.
  - iszero: exp = 00. Denormals are flushed to zero.
- Stage 2 (S2), computed from S1 registers:
  - nan = nanA | nanB | (infA & zeroB) | (zeroA & infB).
  - inf = !nan & (infA | infB).
  - zer = !nan & !inf & (zeroA | zeroB).
  - exp_sum: zero-extend both 8-bit exponents to EXP_W, add them, subtract BIAS, two's-complement result.
  - No clamping in this block; overflow and underflow are resolved downstream.
  - z_sign is computed for every class, NaN included; downstream ignores it for NaN.
- Latency: exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
- Throughput: 1 pair per cycle.
- Handshake:
  - A stage advances when its successor is empty or is being consumed the same cycle.
  - in_ready = !s1_valid | s2_advance.
  - s2_advance = !out_valid | out_ready.
  - in_ready must not depend combinationally on in_valid.
  - While out_valid && !out_ready, all outputs hold stable.
  - No data is lost or duplicated under any stall pattern.
  - Simultaneous accept and drain in one cycle is supported.
- Sticky flags:
  - Set on an out_valid && out_ready transfer carrying nan or inf, respectively.
  - sticky_clr takes priority over a same-cycle set.
- Reset mid-operation drops all in-flight pairs; out_valid falls asynchronously.
- Boundaries:
  - Max exponents: FE+FE−127 = 381.
  - Min exponents: 01+01−127 = −125.
  - Both values must fit in EXP_W without wrap.

Test Plan:
- A=0x3F800000, B=0x40000000, out_ready=1 → 2 cycles later: out_valid=1, z_sign=0, exp_sum=128, man_a=0x800000, man_b=0x800000, nan=inf=zer=0.
- A=0x7F800000, B=0x00000000 → nan=1, inf=0, zer=0; sticky_nan=1 after transfer. A=0xFF800000, B=0x3F800000 → inf=1, z_sign=1.
- A=0x00000001 (denormal), B=0xC0000000 → zer=1, z_sign=1, man_a=0. A=0x7FC00000, B=0x7F800000 → nan=1.
- Stream 8 back-to-back pairs while toggling out_ready in a 1-0-0-1 pattern → all 8 results delivered in order, none dropped or duplicated, outputs stable while stalled.
- Exponent extremes: A=B=0x7F7FFFFF → exp_sum=381. A=B=0x00800000 → exp_sum=−125 (0x383 for EXP_W=10).
- rst asserted with 2 pairs in flight → out_valid=0 immediately. First pair after reset release returns with 2-cycle latency. sticky_clr asserted in the same cycle as a NaN transfer → sticky_nan=0.

Source files
------------

// File: rtl/fpm_operand_unpack_if.sv
// Operand/result bus of the FP multiplier front end: operand pair handshake,
// unpacked result fields, special-case flags and sticky exception status.
interface fpm_operand_unpack_if #(
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      a;
    logic [31:0]      b;
    logic             out_valid;
    logic             out_ready;
    logic             z_sign;
    logic [EXP_W-1:0] exp_sum;
    logic [23:0]      man_a;
    logic [23:0]      man_b;
    logic             nan;
    logic             inf;
    logic             zer;
    logic             sticky_nan;
    logic             sticky_inf;
    logic             sticky_clr;

    // Block side: consumes operands, produces unpacked fields.
    modport slave (
        input  in_valid, a, b, out_ready, sticky_clr,
        output in_ready, out_valid, z_sign, exp_sum, man_a, man_b,
               nan, inf, zer, sticky_nan, sticky_inf
    );

    // Producer/consumer side: drives operands, accepts results.
    modport master (
        output in_valid, a, b, out_ready, sticky_clr,
        input  in_ready, out_valid, z_sign, exp_sum, man_a, man_b,
               nan, inf, zer, sticky_nan, sticky_inf
    );
endinterface

// File: rtl/fpm_operand_unpack.sv
// Front end of the binary32 multiplier: classifies both operands, flushes
// denormals to zero and produces sign, biased exponent sum, hidden-bit
// mantissas and nan/inf/zero flags through a 2-stage back-pressured pipeline.
// Sticky nan/inf status records special results handed downstream.
module fpm_operand_unpack #(
    parameter int BIAS  = 127,
    parameter int EXP_W = 10
) (
    input logic                  clk,
    input logic                  rst,
    fpm_operand_unpack_if.slave  bus
);

    localparam logic [EXP_W-1:0] BIAS_W = EXP_W'(BIAS);

    // Operand class as {is_nan, is_inf, is_zero}; exponent 00 covers denormals.
    function automatic logic [2:0] classify(input logic [7:0] e, input logic [22:0] f);
        logic [2:0] c;
        c = 3'b000;
        if (e == 8'hFF) begin
            if (f != 23'd0) begin
                c = 3'b100;
            end else begin
                c = 3'b010;
            end
        end else if (e == 8'h00) begin
            c = 3'b001;
        end else begin
            c = 3'b000;
        end
        return c;
    endfunction

    // Stage 1 registers
    logic             r_s1_valid;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [2:0]       r_s1_cls_a;
    logic [2:0]       r_s1_cls_b;

    // Stage 2 (output) registers
    logic             r_out_valid;
    logic             r_z_sign;
    logic [EXP_W-1:0] r_exp_sum;
    logic [23:0]      r_man_a;
    logic [23:0]      r_man_b;
    logic             r_nan;
    logic             r_inf;
    logic             r_zer;
    logic             r_sticky_nan;
    logic             r_sticky_inf;

    // Handshake and stage-2 next values
    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_nan;
    logic             w_inf;
    logic             w_zer;
    logic             w_sign;
    logic [EXP_W-1:0] w_exp_sum;
    logic [23:0]      w_man_a;
    logic [23:0]      w_man_b;
    logic             w_xfer;

    // Advance conditions: a stage moves when its successor is empty or draining.
    always_comb begin
        w_s2_adv   = !r_out_valid || bus.out_ready;
        w_in_ready = !r_s1_valid || w_s2_adv;
        w_xfer     = r_out_valid && bus.out_ready;
    end

    // Stage 1: capture the accepted operand pair and its classification.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 32'd0;
            r_s1_b     <= 32'd0;
            r_s1_cls_a <= 3'b000;
            r_s1_cls_b <= 3'b000;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_a     <= bus.a;
                r_s1_b     <= bus.b;
                r_s1_cls_a <= classify(bus.a[30:23], bus.a[22:0]);
                r_s1_cls_b <= classify(bus.b[30:23], bus.b[22:0]);
            end
        end
    end

    // Special-case resolution, exponent sum and hidden-bit mantissas from stage 1.
    always_comb begin
        w_nan = r_s1_cls_a[2] || r_s1_cls_b[2]
             || (r_s1_cls_a[1] && r_s1_cls_b[0])
             || (r_s1_cls_a[0] && r_s1_cls_b[1]);
        w_inf = !w_nan && (r_s1_cls_a[1] || r_s1_cls_b[1]);
        w_zer = !w_nan && !w_inf && (r_s1_cls_a[0] || r_s1_cls_b[0]);
        w_sign = r_s1_a[31] ^ r_s1_b[31];
        // No clamping here: overflow/underflow is resolved downstream.
        w_exp_sum = {{(EXP_W-8){1'b0}}, r_s1_a[30:23]}
                  + {{(EXP_W-8){1'b0}}, r_s1_b[30:23]}
                  - BIAS_W;
        if (r_s1_cls_a[0]) begin
            w_man_a = 24'd0;
        end else begin
            w_man_a = {1'b1, r_s1_a[22:0]};
        end
        if (r_s1_cls_b[0]) begin
            w_man_b = 24'd0;
        end else begin
            w_man_b = {1'b1, r_s1_b[22:0]};
        end
    end

    // Stage 2: load results when advancing; hold everything while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_z_sign    <= 1'b0;
            r_exp_sum   <= {EXP_W{1'b0}};
            r_man_a     <= 24'd0;
            r_man_b     <= 24'd0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_zer       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_z_sign  <= w_sign;
                r_exp_sum <= w_exp_sum;
                r_man_a   <= w_man_a;
                r_man_b   <= w_man_b;
                r_nan     <= w_nan;
                r_inf     <= w_inf;
                r_zer     <= w_zer;
            end
        end
    end

    // Sticky exception status: clear wins over a same-cycle delivered nan/inf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_nan <= 1'b0;
            r_sticky_inf <= 1'b0;
        end else if (bus.sticky_clr) begin
            r_sticky_nan <= 1'b0;
            r_sticky_inf <= 1'b0;
        end else begin
            r_sticky_nan <= r_sticky_nan || (w_xfer && r_nan);
            r_sticky_inf <= r_sticky_inf || (w_xfer && r_inf);
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.z_sign     = r_z_sign;
    assign bus.exp_sum    = r_exp_sum;
    assign bus.man_a      = r_man_a;
    assign bus.man_b      = r_man_b;
    assign bus.nan        = r_nan;
    assign bus.inf        = r_inf;
    assign bus.zer        = r_zer;
    assign bus.sticky_nan = r_sticky_nan;
    assign bus.sticky_inf = r_sticky_inf;

endmodule

// File: tb/tb_fpm_operand_unpack.sv
// Directed bench for fpm_operand_unpack: hand-computed vectors, back-pressure
// streaming, exponent extremes, mid-flight reset and sticky-clear priority.
module tb_fpm_operand_unpack;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fpm_operand_unpack_if #(.EXP_W(10)) bus ();

    fpm_operand_unpack #(.BIAS(127), .EXP_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sign;
        logic [9:0]  exp_s;
        logic [23:0] ma;
        logic [23:0] mb;
        logic        nan;
        logic        inf;
        logic        zer;
    } vec_t;

    vec_t vecs [7];
    logic exp_sn;
    logic exp_si;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one pair with out_ready high and check latency, fields, sticky.
    task automatic run_one(input vec_t v);
        bus.in_valid = 1'b1;
        bus.a = v.a;
        bus.b = v.b;
        step();
        bus.in_valid = 1'b0;
        check("lat_c1_ovalid", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_c2_ovalid", 32'(bus.out_valid), 32'd1);
        check("z_sign",  32'(bus.z_sign),  32'(v.sign));
        check("exp_sum", 32'(bus.exp_sum), 32'(v.exp_s));
        check("man_a",   32'(bus.man_a),   32'(v.ma));
        check("man_b",   32'(bus.man_b),   32'(v.mb));
        check("nan",     32'(bus.nan),     32'(v.nan));
        check("inf",     32'(bus.inf),     32'(v.inf));
        check("zer",     32'(bus.zer),     32'(v.zer));
        step();
        exp_sn = exp_sn | v.nan;
        exp_si = exp_si | v.inf;
        check("sticky_nan", 32'(bus.sticky_nan), 32'(exp_sn));
        check("sticky_inf", 32'(bus.sticky_inf), 32'(exp_si));
        check("drained_ovalid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] held_exp;
        logic        stalled;
        int          ai;
        int          oi;

        n_tests = 0;
        n_fail  = 0;
        exp_sn  = 1'b0;
        exp_si  = 1'b0;
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 10'd128,  24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h7F800000, 32'h00000000, 1'b0, 10'd128,  24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'hFF800000, 32'h3F800000, 1'b1, 10'd255,  24'h800000, 24'h800000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h00000001, 32'hC0000000, 1'b1, 10'd1,    24'h000000, 24'h800000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h7FC00000, 32'h7F800000, 1'b0, 10'h17F,  24'hC00000, 24'h800000, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 10'd381,  24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h00800000, 32'h00800000, 1'b0, 10'h383,  24'h800000, 24'h800000, 1'b0, 1'b0, 1'b0};

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.a          = 32'd0;
        bus.b          = 32'd0;
        bus.out_ready  = 1'b1;
        bus.sticky_clr = 1'b0;
        #12;
        check("rst_ovalid",  32'(bus.out_valid),  32'd0);
        check("rst_exp",     32'(bus.exp_sum),    32'd0);
        check("rst_man_a",   32'(bus.man_a),      32'd0);
        check("rst_flags",   {29'd0, bus.nan, bus.inf, bus.zer}, 32'd0);
        check("rst_sticky",  {30'd0, bus.sticky_nan, bus.sticky_inf}, 32'd0);
        check("rst_inready", 32'(bus.in_ready),   32'd1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_one(vecs[i]);
        end

        // Back-to-back stream with out_ready toggling 1-0-0-1.
        ai = 0;
        oi = 0;
        stalled = 1'b0;
        held_exp = 32'd0;
        for (int c = 0; c < 100 && oi < 8; c++) begin
            bus.out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            if (ai < 8) begin
                bus.in_valid = 1'b1;
                bus.a = 32'h3F800000 + (32'(ai) << 23);
                bus.b = 32'h40000000 | 32'(ai);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (stalled) begin
                check("stall_hold", 32'(bus.exp_sum), held_exp);
            end
            stalled = bus.out_valid && !bus.out_ready;
            if (stalled) begin
                held_exp = 32'(bus.exp_sum);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("stream_exp",  32'(bus.exp_sum), 32'(128 + oi));
                check("stream_manb", 32'(bus.man_b),   32'h00800000 | 32'(oi));
                oi++;
            end
            if (bus.in_valid && bus.in_ready) begin
                ai++;
            end
            step();
        end
        check("stream_count", 32'(oi), 32'd8);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("stream_drain", 32'(bus.out_valid), 32'd0);

        // Reset with two pairs in flight.
        bus.in_valid = 1'b1;
        bus.a = vecs[0].a;
        bus.b = vecs[0].b;
        step();
        bus.a = vecs[5].a;
        bus.b = vecs[5].b;
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_ovalid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_ovalid", 32'(bus.out_valid), 32'd0);
        check("async_rst_exp",    32'(bus.exp_sum),   32'd0);
        check("async_rst_sticky", 32'(bus.sticky_nan), 32'd0);
        #1;
        rst = 1'b0;
        exp_sn = 1'b0;
        exp_si = 1'b0;
        step();
        check("post_rst_idle", 32'(bus.out_valid), 32'd0);
        run_one(vecs[0]);

        // sticky_clr in the same cycle as a NaN transfer.
        bus.in_valid = 1'b1;
        bus.a = vecs[1].a;
        bus.b = vecs[1].b;
        step();
        bus.in_valid = 1'b0;
        step();
        check("clr_nan_present", 32'(bus.nan), 32'd1);
        bus.sticky_clr = 1'b1;
        step();
        bus.sticky_clr = 1'b0;
        check("clr_priority", 32'(bus.sticky_nan), 32'd0);
        run_one(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
